sym_err_checker: RTL
====================

SYM_ERR_CHECKER -- requirements
Module: sym_err_checker

Interface
REQ-001 Parameter MAX_DELAY, default 7: largest TX-to-RX alignment delay searched, in symbols.
REQ-002 Parameter LOCK_LEN, default 32: consecutive matches needed to declare lock.
REQ-003 Parameter BLOCK_LEN, default 32: loss-of-lock evaluation block, in symbols.
REQ-004 Parameter LOSS_THRESH, default 8: errors per block that force loss of lock.
REQ-005 Parameter WINDOW, default 1048576: symbols per measurement.
REQ-006 clk  in  1  system clock; the only clock.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 clk_en  in  1  symbol-rate enable, one clk wide.
REQ-009 sym_tx  in  2  transmitted symbol, from the LFSR data stream LSBs.
REQ-010 sym_rx  in  2  received symbol, from the 4-ASK slicer.
REQ-011 clear  in  1  synchronous restart of the measurement.
REQ-012 locked  out  1  alignment found and held.
REQ-013 delay_out  out  3  chosen alignment delay, 0..MAX_DELAY.
REQ-014 sym_count  out  32  symbols compared while locked.
REQ-015 err_count  out  32  mismatched symbols while locked.
REQ-016 sym_correct  out  1  last compared symbol matched.
REQ-017 sym_error  out  1  last compared symbol mismatched.
REQ-018 meas_done  out  1  WINDOW symbols counted.

Function
REQ-019 The block SHALL act only on clk edges with clk_en=1, except for clear and reset; with clk_en=0, all state SHALL hold.
REQ-020 A TX history of MAX_DELAY entries SHALL shift on every enabled edge; delay d compares sym_rx against the sym_tx presented d enabled edges earlier (d=0: current sym_tx).
REQ-021 The state machine SHALL have three states: SEARCH, LOCKED, DONE.
REQ-022 SEARCH: the candidate d starts at 0. On a match, run count +1. On a mismatch, run count = 0 and d = d+1, wrapping MAX_DELAY->0.
REQ-023 SEARCH->LOCKED SHALL occur on the enabled edge where run count reaches LOCK_LEN. At that edge: locked=1, delay_out=d, sym_count=0, err_count=0, block counters = 0.
REQ-024 LOCKED, per enabled edge: sym_count +1; err_count +1 on mismatch; sym_correct and sym_error registered from that comparison, mutually exclusive, one-clk latency, held until the next enabled edge.
REQ-025 In SEARCH and DONE, sym_correct and sym_error SHALL both be 0.
REQ-026 Loss of lock: at the end of each BLOCK_LEN-symbol block, if the block's error count >= LOSS_THRESH, the block SHALL return to SEARCH.
  - locked=0, d=0, run count=0.
  - sym_count and err_count hold their values.
REQ-027 LOCKED->DONE SHALL occur on the edge where sym_count becomes WINDOW: meas_done=1, counters freeze, locked stays 1.
REQ-028 DONE SHALL be exited only by clear or reset.
REQ-029 If the WINDOW edge and a loss-of-lock block end coincide, DONE SHALL take priority.
REQ-030 sym_count and err_count SHALL saturate at all-ones and never wrap.
REQ-031 clear=1 on any edge SHALL, regardless of clk_en:
  - zero both counters, meas_done, locked, delay_out, sym_correct and sym_error;
  - set d=0 and enter SEARCH.
  The concurrent symbol SHALL NOT be counted, and the TX history SHALL still shift if clk_en=1.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 reset=0 SHALL immediately, without waiting for clk, set:
  - state SEARCH, d=0, TX history all 0;
  - all outputs 0.
REQ-034 Reset asserted mid-lock or mid-measurement SHALL discard all progress. After release, operation SHALL restart from SEARCH on the first enabled edge.

Verification
REQ-035 sym_rx = sym_tx delayed 4 enables, random data, error-free -> locked=1, delay_out=4; 1000 symbols later sym_count=1000, err_count=0.
REQ-036 Locked at delay 4, one sym_rx corrupted every 100 symbols -> err_count +1 each time, sym_error pulses for exactly one enabled interval, locked stays 1.
REQ-037 Locked, then sym_rx replaced by independent random data -> locked=0 at the first block end with >=8 errors, counters hold, relock when alignment is restored.
REQ-038 WINDOW=256 -> meas_done=1 exactly when sym_count=256; further symbols leave sym_count=256 and err_count unchanged.
REQ-039 reset pulsed low between clk edges while locked -> all outputs 0 before the next edge; relock after at least LOCK_LEN further symbols.
REQ-040 clear and clk_en high on the same edge while locked -> counters 0, state SEARCH, that symbol uncounted.

Source files
------------

// File: rtl/sym_err_checker.sv
// sym_err_checker: aligns the received symbol stream to the transmitted one
// and counts symbol errors while aligned. In SEARCH it tries candidate delays
// 0..MAX_DELAY until LOCK_LEN consecutive matches occur. In LOCKED it counts
// compared and mismatched symbols, and drops back to SEARCH when any
// BLOCK_LEN-symbol block carries LOSS_THRESH or more errors. It enters DONE
// once WINDOW symbols have been counted.
module sym_err_checker #(
  parameter int unsigned MAX_DELAY   = 7,
  parameter int unsigned LOCK_LEN    = 32,
  parameter int unsigned BLOCK_LEN   = 32,
  parameter int unsigned LOSS_THRESH = 8,
  parameter int unsigned WINDOW      = 1048576
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic [1:0]  sym_tx,
  input  logic [1:0]  sym_rx,
  input  logic        clear,
  output logic        locked,
  output logic [2:0]  delay_out,
  output logic [31:0] sym_count,
  output logic [31:0] err_count,
  output logic        sym_correct,
  output logic        sym_error,
  output logic        meas_done
);

  localparam logic [1:0] S_SEARCH = 2'd0;
  localparam logic [1:0] S_LOCKED = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam int unsigned RW = $clog2(LOCK_LEN + 1);
  localparam int unsigned BW = $clog2(BLOCK_LEN + 1);

  logic [1:0]    r_state;
  logic [2:0]    r_d;
  logic [RW-1:0] r_run;
  logic [BW-1:0] r_blk;
  logic [BW-1:0] r_berr;
  logic [1:0]    r_hist [MAX_DELAY];

  logic [1:0]    w_ref;
  logic          w_match;
  logic [RW-1:0] w_run_nxt;
  logic [BW-1:0] w_blk_nxt;
  logic [BW-1:0] w_berr_nxt;
  logic [2:0]    w_d_nxt;
  logic [31:0]   w_sym_nxt;
  logic [31:0]   w_err_nxt;

  // Select the TX symbol seen d enabled edges ago and compare with RX.
  always_comb begin
    w_ref = sym_tx;
    for (int unsigned i = 1; i <= MAX_DELAY; i++) begin
      if (r_d == 3'(i)) w_ref = r_hist[i-1];
    end
    w_match    = (w_ref == sym_rx);
    w_run_nxt  = r_run + 1'b1;
    w_blk_nxt  = r_blk + 1'b1;
    w_berr_nxt = r_berr + {{(BW-1){1'b0}}, ~w_match};
    w_d_nxt    = (r_d == 3'(MAX_DELAY)) ? 3'd0 : r_d + 3'd1;
    w_sym_nxt  = (&sym_count) ? sym_count : sym_count + 32'd1;
    w_err_nxt  = (&err_count) ? err_count : err_count + 32'd1;
  end

  // TX history shift register; entry 0 is the symbol of the previous enabled edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < MAX_DELAY; i++) r_hist[i] <= '0;
    end else if (clk_en) begin
      r_hist[0] <= sym_tx;
      for (int unsigned i = 1; i < MAX_DELAY; i++) r_hist[i] <= r_hist[i-1];
    end
  end

  // Search/lock/measure state machine and registered outputs.
  // sym_correct/sym_error reflect any edge taken in LOCKED, including the edge
  // that leaves LOCKED; on later SEARCH/DONE edges they are forced low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_SEARCH;
      r_d         <= '0;
      r_run       <= '0;
      r_blk       <= '0;
      r_berr      <= '0;
      locked      <= 1'b0;
      delay_out   <= '0;
      sym_count   <= '0;
      err_count   <= '0;
      sym_correct <= 1'b0;
      sym_error   <= 1'b0;
      meas_done   <= 1'b0;
    end else if (clear) begin
      r_state     <= S_SEARCH;
      r_d         <= '0;
      r_run       <= '0;
      r_blk       <= '0;
      r_berr      <= '0;
      locked      <= 1'b0;
      delay_out   <= '0;
      sym_count   <= '0;
      err_count   <= '0;
      sym_correct <= 1'b0;
      sym_error   <= 1'b0;
      meas_done   <= 1'b0;
    end else if (clk_en) begin
      case (r_state)
        S_SEARCH: begin
          sym_correct <= 1'b0;
          sym_error   <= 1'b0;
          if (w_match) begin
            if (w_run_nxt == RW'(LOCK_LEN)) begin
              r_state   <= S_LOCKED;
              locked    <= 1'b1;
              delay_out <= r_d;
              sym_count <= '0;
              err_count <= '0;
              r_blk     <= '0;
              r_berr    <= '0;
              r_run     <= '0;
            end else begin
              r_run <= w_run_nxt;
            end
          end else begin
            r_run <= '0;
            r_d   <= w_d_nxt;
          end
        end
        S_LOCKED: begin
          sym_count   <= w_sym_nxt;
          if (!w_match) err_count <= w_err_nxt;
          sym_correct <= w_match;
          sym_error   <= ~w_match;
          if (w_sym_nxt == 32'(WINDOW)) begin
            r_state   <= S_DONE;
            meas_done <= 1'b1;
          end else if (w_blk_nxt == BW'(BLOCK_LEN)) begin
            r_blk  <= '0;
            r_berr <= '0;
            if (w_berr_nxt >= BW'(LOSS_THRESH)) begin
              r_state <= S_SEARCH;
              locked  <= 1'b0;
              r_d     <= '0;
              r_run   <= '0;
            end
          end else begin
            r_blk  <= w_blk_nxt;
            r_berr <= w_berr_nxt;
          end
        end
        default: begin
          sym_correct <= 1'b0;
          sym_error   <= 1'b0;
        end
      endcase
    end
  end

endmodule
